// File: rtl/axil_cmd_master_pkg.sv
// rtl/axil_cmd_master_pkg.sv - shared encodings for the AXI4-Lite command master
package axil_cmd_master_pkg;

  // Host-facing response codes
  localparam logic [1:0] ERR_OKAY    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_SLVERR  = 2'b10;
  localparam logic [1:0] ERR_DECERR  = 2'b11;

  // AXI bresp/rresp codes
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WADDR,
    ST_WRESP,
    ST_RADDR,
    ST_RDATA,
    ST_RSP,
    ST_DRAIN
  } state_t;

  // EXOKAY shares its code with TIMEOUT on the host side, so it is folded
  // into OKAY (AXI4-Lite slaves should never return it anyway).
  function automatic logic [1:0] resp_to_err(input logic [1:0] resp);
    case (resp)
      AXI_RESP_SLVERR: return ERR_SLVERR;
      AXI_RESP_DECERR: return ERR_DECERR;
      default:         return ERR_OKAY;
    endcase
  endfunction

endpackage

// File: rtl/axil_timeout_cnt.sv
// rtl/axil_timeout_cnt.sv - per-phase slave response timeout counter
module axil_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic aclk,
  input  logic areset_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear on any phase change, otherwise count the cycles spent waiting
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the TIMEOUT-th waiting cycle of a phase
  assign expire = en && (cnt_q == LAST);

endmodule

// File: rtl/axil_cmd_master.sv
// rtl/axil_cmd_master.sv - single-outstanding command/response to AXI4-Lite master
module axil_cmd_master
  import axil_cmd_master_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_err,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_W-1:2]     awaddr,
  output logic [2:0]            awprot,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_W-1:2]     araddr,
  output logic [2:0]            arprot,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp
);

  localparam int STRB_W = DATA_W / 8;

  state_t              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic [ADDR_W-3:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                b_owed_q, b_owed_d;
  logic                r_owed_q, r_owed_d;
  logic                drain_q, drain_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_err_q, rsp_err_d;
  logic                timeout_fire;
  logic                cnt_clr, cnt_en, cnt_expire;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^cmd_addr[1:0];

  axil_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .aclk     (aclk),
    .areset_n (areset_n),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .expire   (cnt_expire)
  );

  // Next state: bus channels retire on their own handshakes in every state so
  // a timed-out transaction keeps completing through RSP and DRAIN.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    drain_d      = drain_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    timeout_fire = 1'b0;

    awvalid_d = awvalid_q && !awready;
    wvalid_d  = wvalid_q  && !wready;
    arvalid_d = arvalid_q && !arready;
    b_owed_d  = b_owed_q  && !(bready_q && bvalid);
    r_owed_d  = r_owed_q  && !(rready_q && rvalid);

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr[ADDR_W-1:2];
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          awvalid_d   = cmd_write;
          wvalid_d    = cmd_write;
          b_owed_d    = cmd_write;
          arvalid_d   = !cmd_write;
          r_owed_d    = !cmd_write;
          drain_d     = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = ERR_OKAY;
          state_d     = cmd_write ? ST_WADDR : ST_RADDR;
        end
      end
      ST_WADDR: begin
        if (!awvalid_d && !wvalid_d) begin
          state_d = ST_WRESP;
        end else if (cnt_expire) begin
          timeout_fire = 1'b1;
        end
      end
      ST_WRESP: begin
        if (bready_q && bvalid) begin
          rsp_err_d = resp_to_err(bresp);
          state_d   = ST_RSP;
        end else if (cnt_expire) begin
          timeout_fire = 1'b1;
        end
      end
      ST_RADDR: begin
        if (arvalid_q && arready) begin
          state_d = ST_RDATA;
        end else if (cnt_expire) begin
          timeout_fire = 1'b1;
        end
      end
      ST_RDATA: begin
        if (rready_q && rvalid) begin
          rsp_rdata_d = rdata;
          rsp_err_d   = resp_to_err(rresp);
          state_d     = ST_RSP;
        end else if (cnt_expire) begin
          timeout_fire = 1'b1;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_d = drain_q ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!b_owed_d && !r_owed_d) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (timeout_fire) begin
      rsp_err_d   = ERR_TIMEOUT;
      rsp_rdata_d = '0;
      drain_d     = 1'b1;
      state_d     = ST_RSP;
    end

    // Response readies only open once the request side has fully gone out
    bready_d    = b_owed_d && !awvalid_d && !wvalid_d;
    rready_d    = r_owed_d && !arvalid_d;
    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RSP);
    cnt_clr     = (state_d != state_q);
    cnt_en      = (state_q == ST_WADDR) || (state_q == ST_WRESP) ||
                  (state_q == ST_RADDR) || (state_q == ST_RDATA);
  end

  // State and registered outputs
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      b_owed_q    <= 1'b0;
      r_owed_q    <= 1'b0;
      drain_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= ERR_OKAY;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      b_owed_q    <= b_owed_d;
      r_owed_q    <= r_owed_d;
      drain_q     <= drain_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign awvalid   = awvalid_q;
  assign awaddr    = addr_q;
  assign awprot    = 3'b000;
  assign wvalid    = wvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign bready    = bready_q;
  assign arvalid   = arvalid_q;
  assign araddr    = addr_q;
  assign arprot    = 3'b000;
  assign rready    = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// tb/tb_axil_cmd_master.sv - directed bench for axil_cmd_master against a register-file slave model
module tb_axil_cmd_master;

  logic        aclk = 1'b0;
  logic        areset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [4:2]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 aclk = ~aclk;

  axil_cmd_master #(.ADDR_W(5), .DATA_W(32), .TIMEOUT(8)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  // Register-file slave model: 0x00 register1, 0x10 {field2,field1} read-only,
  // 0x14 block1_register3, everything else reads 0 / ignores writes, always OKAY.
  logic        stall_aw = 1'b0;
  logic        stall_b  = 1'b0;
  logic        field1_i = 1'b0;
  logic [2:0]  field2_i = 3'b000;
  logic [31:0] reg1, reg3;
  logic        aw_got, w_got;
  logic [2:0]  aw_a;
  logic [31:0] w_d;
  logic [3:0]  w_s;

  assign awready = !stall_aw && !aw_got && !bvalid;
  assign wready  = !w_got && !bvalid;
  assign arready = !rvalid;
  assign bresp   = 2'b00;
  assign rresp   = 2'b00;

  function automatic logic [31:0] slv_read(input logic [2:0] wa);
    case (wa)
      3'd0:    return reg1;
      3'd4:    return {28'd0, field2_i, field1_i};
      3'd5:    return reg3;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge aclk) begin
    if (!areset_n) begin
      reg1 <= 32'd0; reg3 <= 32'd0; aw_got <= 1'b0; w_got <= 1'b0;
      aw_a <= 3'd0; w_d <= 32'd0; w_s <= 4'd0;
      bvalid <= 1'b0; rvalid <= 1'b0; rdata <= 32'd0;
    end else begin
      if (awvalid && awready) begin aw_got <= 1'b1; aw_a <= awaddr; end
      if (wvalid && wready) begin w_got <= 1'b1; w_d <= wdata; w_s <= wstrb; end
      if (aw_got && w_got && !stall_b) begin
        for (int i = 0; i < 4; i++) begin
          if (w_s[i] && aw_a == 3'd0) reg1[i*8 +: 8] <= w_d[i*8 +: 8];
          if (w_s[i] && aw_a == 3'd5) reg3[i*8 +: 8] <= w_d[i*8 +: 8];
        end
        aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b1;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && arready) begin rvalid <= 1'b1; rdata <= slv_read(araddr); end
      else if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one command; returns edges from acceptance to rsp_valid. With hold=0
  // rsp_ready is high and the single-cycle response pulse is checked.
  task automatic do_cmd(input logic wr, input logic [4:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic hold,
                        output logic [31:0] rd, output logic [1:0] err, output int lat);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge aclk); n++; end
    if (!cmd_ready) check("idle_wait", 32'(cmd_ready), 32'd1);
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    cmd_valid = 1'b1; rsp_ready = !hold;
    @(negedge aclk);
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin @(negedge aclk); lat++; end
    if (!rsp_valid) check("rsp_wait", 32'(rsp_valid), 32'd1);
    rd = rsp_rdata; err = rsp_err;
    if (!hold) begin
      @(negedge aclk);
      check("rsp_1cyc", 32'(rsp_valid), 32'd0);
    end
  endtask

  logic [31:0] rd, cap, r1_snap, r3_snap;
  logic [1:0]  err;
  int          lat, changes, n;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    areset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 5'd0;
    cmd_wdata = 32'd0; cmd_wstrb = 4'd0; rsp_ready = 1'b0;
    repeat (3) @(negedge aclk);
    areset_n = 1'b1;
    @(negedge aclk);

    // Reset state
    check("rst_ctl", {25'd0, awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready}, 32'h1);
    check("rst_data", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);

    // 1. Full-word write to register1
    do_cmd(1'b1, 5'h00, 32'hDEADBEEF, 4'hF, 1'b0, rd, err, lat);
    check("t1_reg1", reg1, 32'hDEADBEEF);
    check("t1_err", 32'(err), 32'd0);
    check("t1_lat", 32'(lat), 32'd3);

    // 2. Read the input fields
    field1_i = 1'b1; field2_i = 3'b101;
    do_cmd(1'b0, 5'h10, 32'd0, 4'h0, 1'b0, rd, err, lat);
    check("t2_rdata", rd, 32'h0000000B);
    check("t2_err", 32'(err), 32'd0);
    check("t2_lat", 32'(lat), 32'd2);

    // 3. Write then read back block1_register3
    do_cmd(1'b1, 5'h14, 32'h12345678, 4'hF, 1'b0, rd, err, lat);
    check("t3_reg3", reg3, 32'h12345678);
    check("t3_wdata_rsp", rd, 32'd0);
    do_cmd(1'b0, 5'h14, 32'd0, 4'h0, 1'b0, rd, err, lat);
    check("t3_readback", rd, 32'h12345678);

    // Partial strobe only touches byte 1
    do_cmd(1'b1, 5'h00, 32'h0000AA00, 4'h2, 1'b0, rd, err, lat);
    check("t3_strb", reg1, 32'hDEADAAEF);

    // 4. Unmapped address
    r1_snap = reg1; r3_snap = reg3;
    do_cmd(1'b1, 5'h1C, 32'hFFFFFFFF, 4'hF, 1'b0, rd, err, lat);
    check("t4_werr", 32'(err), 32'd0);
    do_cmd(1'b0, 5'h1C, 32'd0, 4'h0, 1'b0, rd, err, lat);
    check("t4_rerr", 32'(err), 32'd0);
    check("t4_rdata", rd, 32'd0);
    check("t4_regs", reg1 ^ reg3, r1_snap ^ r3_snap);
    check("t4_reg1", reg1, 32'hDEADAAEF);

    // 5. AW never accepted -> timeout, then drain once released
    stall_aw = 1'b1;
    do_cmd(1'b1, 5'h1C, 32'hA5A5A5A5, 4'hF, 1'b1, rd, err, lat);
    check("t5_lat", 32'(lat), 32'd8);
    check("t5_err", 32'(err), 32'd1);
    check("t5_rdata", rd, 32'd0);
    check("t5_valids", {29'd0, awvalid, wvalid, bready}, 32'b100);
    repeat (3) @(negedge aclk);
    check("t5_aw_hold", {30'd0, awvalid, rsp_valid}, 32'b11);
    rsp_ready = 1'b1;
    @(negedge aclk);
    check("t5_drain", {29'd0, rsp_valid, cmd_ready, awvalid}, 32'b001);
    stall_aw = 1'b0;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge aclk); n++; end
    check("t5_drained", 32'(cmd_ready), 32'd1);
    do_cmd(1'b0, 5'h00, 32'd0, 4'h0, 1'b0, rd, err, lat);
    check("t5_next_cmd", rd, 32'hDEADAAEF);

    // 6. Response back-pressure with a command offered while busy
    do_cmd(1'b0, 5'h14, 32'd0, 4'h0, 1'b1, rd, err, lat);
    cap = rd;
    check("t6_rdata", cap, 32'h12345678);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'h00; cmd_wdata = 32'h0; cmd_wstrb = 4'hF;
    changes = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== cap || rsp_err !== 2'b00 ||
          cmd_ready !== 1'b0 || awvalid !== 1'b0 || arvalid !== 1'b0) changes++;
    end
    check("t6_stable", 32'(changes), 32'd0);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge aclk);
    check("t6_release", {30'd0, rsp_valid, cmd_ready}, 32'b01);
    check("t6_busy_ign", reg1, 32'hDEADAAEF);

    // Reset in the middle of WRESP
    stall_b = 1'b1;
    cmd_write = 1'b1; cmd_addr = 5'h14; cmd_wdata = 32'h0BAD0BAD; cmd_wstrb = 4'hF;
    cmd_valid = 1'b1;
    @(negedge aclk);
    cmd_valid = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    check("t6_in_wresp", {29'd0, bready, awvalid, cmd_ready}, 32'b100);
    areset_n = 1'b0;
    @(negedge aclk);
    check("t6_rst_ctl", {25'd0, awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready}, 32'h1);
    check("t6_rst_rsp", {rsp_rdata[29:0], rsp_err}, 32'd0);
    stall_b = 1'b0;
    areset_n = 1'b1;
    @(negedge aclk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
